// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared widths, opcode/state enums and index type for the ALU issue controller
package alu_issue_pkg;

  localparam int DATA_W   = 4;
  localparam int OP_W     = 2;
  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [IDX_W-1:0]  reg_idx_t;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_READ = 2'b01,
    S_EXEC = 2'b10,
    S_WB   = 2'b11
  } state_e;

  // Only ADD/SUB produce a meaningful carry; logic ops report carry as 0.
  function automatic logic op_is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_issue_rf.sv
// rtl/alu_issue_rf.sv - 4x4-bit register file, two combinational read ports, one synchronous write port
module alu_issue_rf
  import alu_issue_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t raddr1,
  input  reg_idx_t raddr2,
  output data_t    rdata1,
  output data_t    rdata2,
  input  logic     we,
  input  reg_idx_t waddr,
  input  data_t    wdata
);

  data_t mem [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - serialising issue controller feeding an external 4-bit ALU
// Optional status flags (flag_c/flag_z) are built only when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_ld,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_res,
  input  logic       alu_carry,
`ifdef ALU_ISSUE_FLAGS_EN
  output logic       flag_c,
  output logic       flag_z,
`endif
  output logic       wb_valid,
  output logic [1:0] wb_rd,
  output logic [3:0] wb_data
);

  state_e   state_q, state_d;
  op_e      op_q, alu_op_q;
  reg_idx_t rd_q, rs1_q, rs2_q;
  reg_idx_t wb_rd_q;
  data_t    wb_data_q, alu_a_q, alu_b_q;
  data_t    rf_rdata1, rf_rdata2;
  logic     accept;

  assign accept = (state_q == S_IDLE) && cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    wb_valid  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = cmd_ld ? S_WB : S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        wb_valid = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // wb_rd/wb_data are loaded only on entry to WB so they hold between write-backs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_AND;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= OP_AND;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q  <= op_e'(cmd_op);
            rd_q  <= cmd_rd;
            rs1_q <= cmd_rs1;
            rs2_q <= cmd_rs2;
            if (cmd_ld) begin
              wb_rd_q   <= cmd_rd;
              wb_data_q <= cmd_imm;
            end
          end
        end
        S_READ: begin
          alu_a_q  <= rf_rdata1;
          alu_b_q  <= rf_rdata2;
          alu_op_q <= op_q;
        end
        S_EXEC: begin
          wb_rd_q   <= rd_q;
          wb_data_q <= alu_res;
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_ISSUE_FLAGS_EN
  logic carry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      flag_c  <= 1'b0;
      flag_z  <= 1'b0;
    end else begin
      if (accept && cmd_ld)      carry_q <= 1'b0;
      else if (state_q == S_EXEC) carry_q <= op_is_arith(alu_op_q) ? alu_carry : 1'b0;
      if (state_q == S_WB) begin
        flag_c <= carry_q;
        flag_z <= (wb_data_q == '0);
      end
    end
  end
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
`endif

  alu_issue_rf u_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (rs1_q),
    .raddr2 (rs2_q),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (state_q == S_WB),
    .waddr  (wb_rd_q),
    .wdata  (wb_data_q)
  );

  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_op  = alu_op_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule
